// File: rtl/vector_alu_engine_if.sv
// Single-port memory request bus shared by the accelerators.
// The engine drives requests through the master modport; memory answers on the slave side.
interface vector_alu_engine_if #(
  parameter int WA = 32,
  parameter int WD = 32
);
  logic [WA-1:0] MEM_A;
  logic          MEM_RE;
  logic          MEM_WE;
  logic [WD-1:0] MEM_D;
  logic [WD-1:0] MEM_Q;
  logic          MEM_BUSY;
  logic          MEM_DONE;

  modport master (
    output MEM_A, MEM_RE, MEM_WE, MEM_D,
    input  MEM_Q, MEM_BUSY, MEM_DONE
  );

  modport slave (
    input  MEM_A, MEM_RE, MEM_WE, MEM_D,
    output MEM_Q, MEM_BUSY, MEM_DONE
  );
endinterface

// File: rtl/vector_alu_engine.sv
// Memory-mapped vector engine: C[i] = A[i] op B[i] for i < LEN, one element at a time.
// Define VECTOR_ALU_SAT_EN for saturating add/sub; otherwise add/sub wrap modulo 2^WD.
module vector_alu_engine #(
  parameter int WA     = 32,
  parameter int WD     = 32,
  parameter int LW     = 16,
  parameter int STRIDE = 32
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                START,
  input  logic [1:0]          OP,
  input  logic [LW-1:0]       LEN,
  input  logic [WA-1:0]       BASE_A,
  input  logic [WA-1:0]       BASE_B,
  input  logic [WA-1:0]       BASE_C,
  output logic                BUSY,
  output logic                DONE,
  vector_alu_engine_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_RW_A, S_RD_B, S_RW_B, S_CALC, S_WR, S_WW, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] idx_q, idx_d, len_q, len_d;
  logic [WA-1:0] off_q, off_d, base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [WA-1:0] mem_a_q, mem_a_d;
  logic [1:0]    op_q, op_d;
  logic [WD-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, mem_d_q, mem_d_d;
  logic          re_q, re_d, we_q, we_d, busy_q, busy_d, done_q, done_d;

  function automatic logic [WD-1:0] alu_f(input logic [1:0] op, input logic [WD-1:0] a,
                                          input logic [WD-1:0] b);
    logic [WD-1:0] r;
`ifdef VECTOR_ALU_SAT_EN
    logic [WD:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`endif
    case (op)
`ifdef VECTOR_ALU_SAT_EN
      2'd0:    r = sum[WD] ? {WD{1'b1}} : sum[WD-1:0];
      2'd1:    r = (a < b) ? {WD{1'b0}} : (a - b);
`else
      2'd0:    r = a + b;
      2'd1:    r = a - b;
`endif
      2'd2:    r = a ^ b;
      default: r = (a > b) ? a : b;
    endcase
    return r;
  endfunction

  // Register bank; the asynchronous reset also drops the strobes mid-run.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= S_IDLE;
      idx_q    <= {LW{1'b0}};
      len_q    <= {LW{1'b0}};
      off_q    <= {WA{1'b0}};
      base_a_q <= {WA{1'b0}};
      base_b_q <= {WA{1'b0}};
      base_c_q <= {WA{1'b0}};
      mem_a_q  <= {WA{1'b0}};
      op_q     <= 2'd0;
      opa_q    <= {WD{1'b0}};
      opb_q    <= {WD{1'b0}};
      res_q    <= {WD{1'b0}};
      mem_d_q  <= {WD{1'b0}};
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      off_q    <= off_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      mem_a_q  <= mem_a_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      mem_d_q  <= mem_d_d;
      re_q     <= re_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and request sequencing. Issue states raise the strobe once the bus is
  // free and keep it up until the memory signals acceptance with MEM_BUSY.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    off_d    = off_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    mem_a_d  = mem_a_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    mem_d_d  = mem_d_q;
    re_d     = re_q;
    we_d     = we_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (START && !busy_q) begin
          op_d     = OP;
          len_d    = LEN;
          base_a_d = BASE_A;
          base_b_d = BASE_B;
          base_c_d = BASE_C;
          idx_d    = {LW{1'b0}};
          off_d    = {WA{1'b0}};
          busy_d   = 1'b1;
          if (LEN == {LW{1'b0}}) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        if (!re_q) begin
          if (!bus.MEM_BUSY) begin
            re_d    = 1'b1;
            mem_a_d = base_a_q + off_q;
          end else begin
            re_d = 1'b0;
          end
        end else if (bus.MEM_BUSY) begin
          re_d    = 1'b0;
          state_d = S_RW_A;
        end else begin
          re_d = 1'b1;
        end
      end
      S_RW_A: begin
        if (bus.MEM_DONE) begin
          opa_d   = bus.MEM_Q;
          state_d = S_RD_B;
        end else begin
          state_d = S_RW_A;
        end
      end
      S_RD_B: begin
        if (!re_q) begin
          if (!bus.MEM_BUSY) begin
            re_d    = 1'b1;
            mem_a_d = base_b_q + off_q;
          end else begin
            re_d = 1'b0;
          end
        end else if (bus.MEM_BUSY) begin
          re_d    = 1'b0;
          state_d = S_RW_B;
        end else begin
          re_d = 1'b1;
        end
      end
      S_RW_B: begin
        if (bus.MEM_DONE) begin
          opb_d   = bus.MEM_Q;
          state_d = S_CALC;
        end else begin
          state_d = S_RW_B;
        end
      end
      S_CALC: begin
        res_d   = alu_f(op_q, opa_q, opb_q);
        state_d = S_WR;
      end
      S_WR: begin
        if (!we_q) begin
          if (!bus.MEM_BUSY) begin
            we_d    = 1'b1;
            mem_a_d = base_c_q + off_q;
            mem_d_d = res_q;
          end else begin
            we_d = 1'b0;
          end
        end else if (bus.MEM_BUSY) begin
          we_d    = 1'b0;
          state_d = S_WW;
        end else begin
          we_d = 1'b1;
        end
      end
      S_WW: begin
        if (bus.MEM_DONE) begin
          idx_d = idx_q + LW'(1);
          off_d = off_q + WA'(STRIDE);
          if ((idx_q + LW'(1)) == len_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD_A;
          end
        end else begin
          state_d = S_WW;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign bus.MEM_A  = mem_a_q;
  assign bus.MEM_RE = re_q;
  assign bus.MEM_WE = we_q;
  assign bus.MEM_D  = mem_d_q;

endmodule

// File: tb/tb_vector_alu_engine.sv
// Self-checking bench for vector_alu_engine: behavioural memory with optional random
// stretch, write scoreboard fed at stimulus time, reference ALU model.
module tb_vector_alu_engine;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK;
  logic        RST_X;
  logic        START;
  logic [1:0]  OP;
  logic [15:0] LEN;
  logic [31:0] BASE_A, BASE_B, BASE_C;
  logic        BUSY, DONE;

  vector_alu_engine_if #(.WA(32), .WD(32)) mif ();

  vector_alu_engine #(.WA(32), .WD(32), .LW(16), .STRIDE(32)) dut (
    .CLK(CLK), .RST_X(RST_X), .START(START), .OP(OP), .LEN(LEN),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .BASE_C(BASE_C),
    .BUSY(BUSY), .DONE(DONE), .bus(mif)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          strobe_cnt = 0;
  int          both_cnt = 0;
  bit          rand_en = 1'b0;
  int          hold_fix = 0;
  wr_t         exp_q[$];
  logic [31:0] mem_arr [logic [31:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
`ifdef VECTOR_ALU_SAT_EN
      2'd0:    return s[32] ? 32'hFFFF_FFFF : s[31:0];
      2'd1:    return (a < b) ? 32'h0 : (a - b);
`else
      2'd0:    return s[31:0];
      2'd1:    return a - b;
`endif
      2'd2:    return a ^ b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] el(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'd32;
  endfunction

  // Bus monitor sampled mid-cycle.
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (mif.MEM_RE || mif.MEM_WE) strobe_cnt++;
    if (mif.MEM_RE && mif.MEM_WE) both_cnt++;
  end

  // Memory model: accept after a delay, hold MEM_BUSY, then one MEM_DONE cycle.
  initial begin : mem_model
    int          m_st;
    int          m_cnt;
    logic        m_wr;
    logic [31:0] m_addr, m_data;
    wr_t         e;
    m_st = 0;
    m_cnt = 0;
    m_wr = 1'b0;
    m_addr = 32'h0;
    m_data = 32'h0;
    mif.MEM_BUSY = 1'b0;
    mif.MEM_DONE = 1'b0;
    mif.MEM_Q = 32'hDEAD_BEEF;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_X) begin
        m_st = 0;
        mif.MEM_BUSY = 1'b0;
        mif.MEM_DONE = 1'b0;
        mif.MEM_Q = 32'hDEAD_BEEF;
      end else begin
        case (m_st)
          0: begin
            mif.MEM_DONE = 1'b0;
            mif.MEM_Q = 32'hDEAD_BEEF;
            if (mif.MEM_RE || mif.MEM_WE) begin
              m_wr = mif.MEM_WE;
              m_addr = mif.MEM_A;
              m_data = mif.MEM_D;
              if (m_wr) begin
                if (exp_q.size() == 0) begin
                  check("wr_unexpected", {32'h0, m_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", {32'h0, m_addr}, {32'h0, e.addr});
                  check("wr_data", {32'h0, m_data}, {32'h0, e.data});
                end
              end
              m_cnt = rand_en ? int'($urandom_range(0, 5)) : 0;
              m_st = 1;
            end
          end
          1: begin
            if (m_cnt == 0) begin
              mif.MEM_BUSY = 1'b1;
              m_cnt = rand_en ? int'($urandom_range(0, 5)) : hold_fix;
              m_st = 2;
            end else begin
              m_cnt--;
            end
          end
          2: begin
            if (m_cnt == 0) begin
              mif.MEM_BUSY = 1'b0;
              mif.MEM_DONE = 1'b1;
              if (m_wr) mem_arr[m_addr] = m_data;
              else mif.MEM_Q = rd_mem(m_addr);
              m_st = 0;
            end else begin
              m_cnt--;
            end
          end
          default: m_st = 0;
        endcase
      end
    end
  end

  task automatic start_run(input logic [1:0] op, input logic [15:0] len,
                           input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
    OP = op; LEN = len; BASE_A = ba; BASE_B = bb; BASE_C = bc;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    OP = ~op; LEN = 16'hFFFF; BASE_A = 32'h0; BASE_B = 32'h0; BASE_C = 32'h0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int cyc;
    cyc = 0;
    while (!DONE && cyc < limit) begin
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_done_seen"}, {63'h0, DONE}, 64'h1);
  endtask

  // Expectations for C[i] must already be queued; bases must already be preloaded.
  task automatic run_check(input string tag, input logic [1:0] op, input logic [15:0] len,
                           input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
    int d0;
    d0 = done_cnt;
    start_run(op, len, ba, bb, bc);
    check({tag, "_busy"}, {63'h0, BUSY}, 64'h1);
    wait_done(tag, 4000);
    repeat (2) @(negedge CLK);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'h1);
    check({tag, "_busy_after"}, {63'h0, BUSY}, 64'h0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vc [4];
    int          d0, s0;

    RST_X = 1'b0; START = 1'b1; OP = 2'd0; LEN = 16'd4;
    BASE_A = 32'h100; BASE_B = 32'h400; BASE_C = 32'h800;
    repeat (3) @(negedge CLK);
    check("rst_busy", {63'h0, BUSY}, 64'h0);
    check("rst_done", {63'h0, DONE}, 64'h0);
    check("rst_re", {63'h0, mif.MEM_RE}, 64'h0);
    check("rst_we", {63'h0, mif.MEM_WE}, 64'h0);
    check("rst_addr", {32'h0, mif.MEM_A}, 64'h0);
    check("rst_wdata", {32'h0, mif.MEM_D}, 64'h0);
    START = 1'b0;
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_busy", {63'h0, BUSY}, 64'h0);

    va = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
    vb = '{32'd10, 32'd20, 32'd30, 32'd2};
`ifdef VECTOR_ALU_SAT_EN
    vc = '{32'd11, 32'd22, 32'd33, 32'hFFFF_FFFF};
`else
    vc = '{32'd11, 32'd22, 32'd33, 32'd1};
`endif
    for (int i = 0; i < 4; i++) begin
      mem_arr[el(32'h100, i)] = va[i];
      mem_arr[el(32'h400, i)] = vb[i];
      push_exp(el(32'h800, i), vc[i]);
    end
    run_check("add4", 2'd0, 16'd4, 32'h100, 32'h400, 32'h800);

    mem_arr[32'h100] = 32'd5;
    mem_arr[32'h400] = 32'd7;
`ifdef VECTOR_ALU_SAT_EN
    push_exp(32'h800, 32'h0);
`else
    push_exp(32'h800, 32'hFFFF_FFFE);
`endif
    run_check("sub1", 2'd1, 16'd1, 32'h100, 32'h400, 32'h800);
    push_exp(32'h800, 32'd7);
    run_check("max1", 2'd3, 16'd1, 32'h100, 32'h400, 32'h800);
    mem_arr[32'h100] = 32'hF0;
    mem_arr[32'h400] = 32'hFF;
    push_exp(32'h800, 32'h0F);
    run_check("xor1", 2'd2, 16'd1, 32'h100, 32'h400, 32'h800);

    s0 = strobe_cnt;
    d0 = done_cnt;
    start_run(2'd0, 16'd0, 32'h100, 32'h400, 32'h800);
    check("len0_busy_c1", {63'h0, BUSY}, 64'h1);
    check("len0_done_c1", {63'h0, DONE}, 64'h0);
    @(negedge CLK);
    check("len0_done_c2", {63'h0, DONE}, 64'h1);
    @(negedge CLK);
    check("len0_done_c3", {63'h0, DONE}, 64'h0);
    check("len0_busy_c3", {63'h0, BUSY}, 64'h0);
    check("len0_pulses", 64'(done_cnt - d0), 64'h1);
    check("len0_no_strobe", 64'(strobe_cnt - s0), 64'h0);

    rand_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_arr[el(32'h1000, i)] = $urandom;
      mem_arr[el(32'h1800, i)] = (i % 4 == 0) ? 32'hFFFF_FFF0 : $urandom;
      push_exp(el(32'h2000, i), ref_alu(2'd0, mem_arr[el(32'h1000, i)], mem_arr[el(32'h1800, i)]));
    end
    d0 = done_cnt;
    start_run(2'd0, 16'd16, 32'h1000, 32'h1800, 32'h2000);
    repeat (40) @(negedge CLK);
    check("rnd_busy_mid", {63'h0, BUSY}, 64'h1);
    OP = 2'd2; LEN = 16'd1; BASE_A = 32'h0; BASE_B = 32'h0; BASE_C = 32'h5000;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("rnd16", 8000);
    repeat (2) @(negedge CLK);
    check("rnd16_done_pulses", 64'(done_cnt - d0), 64'h1);
    check("rnd16_sb_empty", 64'(exp_q.size()), 64'h0);
    repeat (10) @(negedge CLK);
    check("rnd16_no_restart", {63'h0, BUSY}, 64'h0);

    rand_en = 1'b0;
    hold_fix = 3;
    for (int i = 0; i < 4; i++) begin
      mem_arr[el(32'h100, i)] = 32'd100 + 32'(i);
      mem_arr[el(32'h400, i)] = 32'd200 + 32'(i);
      push_exp(el(32'h800, i), 32'd300 + 32'd2 * 32'(i));
    end
    d0 = done_cnt;
    start_run(2'd0, 16'd4, 32'h100, 32'h400, 32'h800);
    begin
      int cyc;
      cyc = 0;
      while (!(mif.MEM_BUSY && !mif.MEM_RE && mif.MEM_A == el(32'h400, 2)) && cyc < 500) begin
        @(negedge CLK);
        cyc++;
      end
      check("abort_reached_rwb", {63'h0, (cyc < 500)}, 64'h1);
    end
    RST_X = 1'b0;
    #1;
    check("abort_re", {63'h0, mif.MEM_RE}, 64'h0);
    check("abort_we", {63'h0, mif.MEM_WE}, 64'h0);
    check("abort_busy", {63'h0, BUSY}, 64'h0);
    check("abort_sb_two_written", 64'(exp_q.size()), 64'h2);
    repeat (3) @(negedge CLK);
    RST_X = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    check("abort_no_done", 64'(done_cnt - d0), 64'h0);
    hold_fix = 0;
    for (int i = 0; i < 3; i++) begin
      push_exp(el(32'h3000, i), 32'd300 + 32'd2 * 32'(i));
    end
    run_check("post_abort", 2'd0, 16'd3, 32'h100, 32'h400, 32'h3000);

    check("re_we_exclusive", 64'(both_cnt), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
